// File: rtl/wishbus_mem_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : wishbus_mem_resp_if
// Description : Bus bundle for the wishbus_mem_resp memory responder.
//               The master drives the request side and the slave drives
//               the response side.
// Revision    : 1.0 - initial release
// ============================================================================
interface wishbus_mem_resp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [DATA_W/8-1:0]   sel_i;
  logic [ADDR_W-1:0]     addr_i;
  logic [DATA_W-1:0]     dat_i;
  logic [DATA_W-1:0]     dat_o;
  logic                  ack_o;
  logic                  err_o;
  logic                  busy_o;

  modport master (
    output cyc_i, stb_i, we_i, sel_i, addr_i, dat_i,
    input  dat_o, ack_o, err_o, busy_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, sel_i, addr_i, dat_i,
    output dat_o, ack_o, err_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/wishbus_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : wishbus_mem_resp
// Description : Single-port word memory behind a Wishbone-style handshake.
//               A request is accepted in IDLE, waits WAIT_ST cycles and is
//               answered with a one-cycle ack (or err) in RESP.
//               Optional macro WISHBUS_MEM_RESP_ERR_EN: addresses >= DEPTH
//               are answered with err_o instead of wrapping modulo DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbus_mem_resp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 768,
  parameter int WAIT_ST = 1
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  wishbus_mem_resp_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W:0] c_depth     = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      c_wait_last = (WAIT_ST > 0) ? 4'(WAIT_ST - 1) : 4'd0;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_wait = 2'd1;
  localparam logic [1:0] c_resp = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [NB-1:0]     sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dat_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              w_accept;
  logic              w_resp;
  logic              w_oor;
  logic              w_mem_we;
  logic [ADDR_W:0]   w_mod;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_mask;
  logic              w_unused_mod;

  assign w_accept = (state_q == c_idle) & bus.cyc_i & bus.stb_i;
  assign w_resp   = (state_q == c_resp);

  // Word index: the latched address folded into the implemented range.
  assign w_mod        = {1'b0, addr_q} % c_depth;
  assign w_idx        = w_mod[IDX_W-1:0];
  assign w_unused_mod = ^w_mod[ADDR_W:IDX_W];

  // Byte-lane mask built from the latched byte enables.
  for (genvar b = 0; b < NB; b++) begin : g_mask
    assign w_mask[b*8 +: 8] = {8{sel_q[b]}};
  end

`ifdef WISHBUS_MEM_RESP_ERR_EN
  assign w_oor      = ({1'b0, addr_q} >= c_depth);
  assign bus.ack_o  = w_resp & ~w_oor;
  assign bus.err_o  = w_resp & w_oor;
`else
  assign w_oor      = 1'b0;
  assign bus.ack_o  = w_resp;
  assign bus.err_o  = 1'b0;
`endif

  assign bus.busy_o = (state_q != c_idle);
  assign bus.dat_o  = (w_resp & ~we_q & ~w_oor) ? (mem_q[w_idx] & w_mask) : '0;
  assign w_mem_we   = w_resp & we_q & ~w_oor;

  // Next-state logic: IDLE -> WAIT (optional) -> RESP -> IDLE, abort on cyc_i low in WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_idle: begin
        cnt_d = 4'd0;
        if (w_accept) begin
          state_d = (WAIT_ST > 0) ? c_wait : c_resp;
        end
      end
      c_wait: begin
        if (!bus.cyc_i) begin
          state_d = c_idle;
          cnt_d   = 4'd0;
        end else if (cnt_q == c_wait_last) begin
          state_d = c_resp;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      c_resp: begin
        state_d = c_idle;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = c_idle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, wait counter and request capture registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= c_idle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        we_q   <= bus.we_i;
        sel_q  <= bus.sel_i;
        addr_q <= bus.addr_i;
        dat_q  <= bus.dat_i;
      end
    end
  end

  // Memory array keeps its contents across reset; writes land in RESP per enabled lane.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_q[b]) begin
          mem_q[w_idx][b*8 +: 8] <= dat_q[b*8 +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wishbus_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_wishbus_mem_resp
// Description : Directed self-checking bench for wishbus_mem_resp with three
//               instances (WAIT_ST = 1, 3, 0) sharing the request signals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbus_mem_resp;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [9:0]  addr;
  logic [31:0] wdat;
  int          dut_sel;

  int errors = 0;
  int checks = 0;

  logic        o_ack, o_err, o_busy;
  logic [31:0] o_dat;

  wishbus_mem_resp_if #(.DATA_W(32), .ADDR_W(10)) if0 ();
  wishbus_mem_resp_if #(.DATA_W(32), .ADDR_W(10)) if1 ();
  wishbus_mem_resp_if #(.DATA_W(32), .ADDR_W(10)) if2 ();

  wishbus_mem_resp #(.DATA_W(32), .ADDR_W(10), .DEPTH(768), .WAIT_ST(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if0.slave));
  wishbus_mem_resp #(.DATA_W(32), .ADDR_W(10), .DEPTH(768), .WAIT_ST(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if1.slave));
  wishbus_mem_resp #(.DATA_W(32), .ADDR_W(10), .DEPTH(768), .WAIT_ST(0)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if2.slave));

  assign if0.cyc_i = cyc & (dut_sel == 0);
  assign if0.stb_i = stb & (dut_sel == 0);
  assign if1.cyc_i = cyc & (dut_sel == 1);
  assign if1.stb_i = stb & (dut_sel == 1);
  assign if2.cyc_i = cyc & (dut_sel == 2);
  assign if2.stb_i = stb & (dut_sel == 2);
  assign if0.we_i = we;   assign if1.we_i = we;   assign if2.we_i = we;
  assign if0.sel_i = sel; assign if1.sel_i = sel; assign if2.sel_i = sel;
  assign if0.addr_i = addr; assign if1.addr_i = addr; assign if2.addr_i = addr;
  assign if0.dat_i = wdat; assign if1.dat_i = wdat; assign if2.dat_i = wdat;

  // Route the selected instance's response to common observation signals.
  always_comb begin
    o_ack = if0.ack_o; o_err = if0.err_o; o_busy = if0.busy_o; o_dat = if0.dat_o;
    if (dut_sel == 1) begin
      o_ack = if1.ack_o; o_err = if1.err_o; o_busy = if1.busy_o; o_dat = if1.dat_o;
    end else if (dut_sel == 2) begin
      o_ack = if2.ack_o; o_err = if2.err_o; o_busy = if2.busy_o; o_dat = if2.dat_o;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete transfer on the selected instance; lat = negedges after the accept edge.
  task automatic xfer(input logic w, input logic [3:0] s, input logic [9:0] a,
                      input logic [31:0] d, output logic g_ack, output logic g_err,
                      output logic [31:0] g_dat, output int lat, output logic idle_after);
    g_ack = 1'b0; g_err = 1'b0; g_dat = '0; lat = 0; idle_after = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; addr = a; wdat = d;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (o_ack || o_err) begin
        g_ack = o_ack; g_err = o_err; g_dat = o_dat; lat = n;
        break;
      end
      stb = 1'b0;
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    idle_after = !o_ack && !o_err && !o_busy && (o_dat == 32'd0);
  endtask

  task automatic test_reset();
    dut_sel = 0; cyc = 0; stb = 0; we = 0; sel = 0; addr = 0; wdat = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (if0.ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", if0.ack_o); end
    checks++; if (if0.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", if0.err_o); end
    checks++; if (if0.dat_o !== 32'd0) begin errors++; $display("FAIL reset_dat: got %h want 0", if0.dat_o); end
    checks++; if ({if0.busy_o, if1.busy_o, if2.busy_o} !== 3'b000) begin errors++;
      $display("FAIL reset_busy: got %b want 000", {if0.busy_o, if1.busy_o, if2.busy_o}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic a, e, ok; logic [31:0] d; int lat;
    dut_sel = 0;
    xfer(1'b1, 4'hF, 10'd5, 32'hDEADBEEF, a, e, d, lat, ok);
    checks++; if (a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL wr_ack: got ack=%b err=%b want ack=1 err=0", a, e); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL wr_dat_zero: got %h want 0", d); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_one_cycle: got %b want 1", ok); end
    xfer(1'b0, 4'hF, 10'd5, 32'h0, a, e, d, lat, ok);
    checks++; if (a !== 1'b1 || lat !== 2) begin errors++; $display("FAIL rd_ack_lat: got ack=%b lat=%0d want ack=1 lat=2", a, lat); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", d); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_dat_after: got %b want 1", ok); end
  endtask

  task automatic test_byte_lanes();
    logic a, e, ok; logic [31:0] d; int lat;
    dut_sel = 0;
    xfer(1'b1, 4'hF, 10'd7, 32'h11223344, a, e, d, lat, ok);
    xfer(1'b1, 4'h3, 10'd7, 32'hAABBCCDD, a, e, d, lat, ok);
    xfer(1'b0, 4'hF, 10'd7, 32'h0, a, e, d, lat, ok);
    checks++; if (d !== 32'h1122CCDD) begin errors++; $display("FAIL lane_merge: got %h want 1122ccdd", d); end
    xfer(1'b0, 4'h5, 10'd7, 32'h0, a, e, d, lat, ok);
    checks++; if (d !== 32'h002200DD) begin errors++; $display("FAIL lane_read_mask: got %h want 002200dd", d); end
    xfer(1'b1, 4'h0, 10'd7, 32'hFFFFFFFF, a, e, d, lat, ok);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL sel0_ack: got %b want 1", a); end
    xfer(1'b0, 4'hF, 10'd7, 32'h0, a, e, d, lat, ok);
    checks++; if (d !== 32'h1122CCDD) begin errors++; $display("FAIL sel0_unchanged: got %h want 1122ccdd", d); end
  endtask

  task automatic test_abort();
    logic a, e, ok, seen; logic [31:0] d; int lat;
    dut_sel = 1;
    xfer(1'b1, 4'hF, 10'd9, 32'h0BADF00D, a, e, d, lat, ok);
    checks++; if (a !== 1'b1 || lat !== 4) begin errors++; $display("FAIL wait3_latency: got ack=%b lat=%0d want ack=1 lat=4", a, lat); end
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; sel = 4'hF; addr = 10'd9; wdat = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_wait: got %b want 1", o_busy); end
    cyc = 0; stb = 0;
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy_low: got %b want 0", o_busy); end
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen = seen | o_ack | o_err; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_resp: got %b want 0", seen); end
    xfer(1'b0, 4'hF, 10'd9, 32'h0, a, e, d, lat, ok);
    checks++; if (d !== 32'h0BADF00D) begin errors++; $display("FAIL abort_mem: got %h want 0badf00d", d); end
  endtask

  task automatic test_out_of_range();
    logic a, e, ok; logic [31:0] d; int lat;
    dut_sel = 0;
    xfer(1'b1, 4'hF, 10'd32, 32'h32323232, a, e, d, lat, ok);
    xfer(1'b0, 4'hF, 10'd800, 32'h0, a, e, d, lat, ok);
`ifdef WISHBUS_MEM_RESP_ERR_EN
    checks++; if (e !== 1'b1 || a !== 1'b0) begin errors++; $display("FAIL oor_err: got ack=%b err=%b want ack=0 err=1", a, e); end
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL oor_dat: got %h want 0", d); end
`else
    checks++; if (a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL wrap_ack: got ack=%b err=%b want ack=1 err=0", a, e); end
    checks++; if (d !== 32'h32323232) begin errors++; $display("FAIL wrap_dat: got %h want 32323232", d); end
`endif
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL oor_one_cycle: got %b want 1", ok); end
  endtask

  task automatic test_reset_mid_wait();
    logic a, e, ok, seen; logic [31:0] d; int lat;
    dut_sel = 1;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; sel = 4'hF; addr = 10'd9; wdat = 32'hCAFECAFE;
    @(posedge clk);
    @(negedge clk);
    stb = 0;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b want 1", o_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({o_busy, o_ack, o_err} !== 3'b000 || o_dat !== 32'd0) begin errors++;
      $display("FAIL rst_async_outputs: got busy/ack/err=%b dat=%h want 000/0", {o_busy, o_ack, o_err}, o_dat); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen = seen | o_ack | o_err; end
    cyc = 0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_resp: got %b want 0", seen); end
    xfer(1'b0, 4'hF, 10'd9, 32'h0, a, e, d, lat, ok);
    checks++; if (d !== 32'h0BADF00D) begin errors++; $display("FAIL rst_no_write: got %h want 0badf00d", d); end
    dut_sel = 0;
    xfer(1'b0, 4'hF, 10'd5, 32'h0, a, e, d, lat, ok);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_mem_kept: got %h want deadbeef", d); end
  endtask

  task automatic test_back_to_back();
    logic a, e, ok; logic [31:0] d, d1; int lat; logic [5:0] pat;
    dut_sel = 2;
    xfer(1'b1, 4'hF, 10'd3, 32'hA5A55A5A, a, e, d, lat, ok);
    checks++; if (a !== 1'b1 || lat !== 1) begin errors++; $display("FAIL w0_wr_latency: got ack=%b lat=%0d want ack=1 lat=1", a, lat); end
    xfer(1'b0, 4'hF, 10'd3, 32'h0, a, e, d, lat, ok);
    checks++; if (lat !== 1 || d !== 32'hA5A55A5A) begin errors++; $display("FAIL w0_rd: got lat=%0d dat=%h want lat=1 dat=a5a55a5a", lat, d); end
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; sel = 4'hF; addr = 10'd3;
    d1 = '0; pat = '0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      pat[n] = o_ack;
      if (n == 0) d1 = o_dat;
    end
    cyc = 0; stb = 0;
    checks++; if (pat !== 6'b010101) begin errors++; $display("FAIL b2b_gap: got %b want 010101", pat); end
    checks++; if (d1 !== 32'hA5A55A5A) begin errors++; $display("FAIL b2b_dat: got %h want a5a55a5a", d1); end
  endtask

  // The response outputs must never both be high on any instance.
  always @(negedge clk) begin
    if (rst_n && ((if0.ack_o & if0.err_o) | (if1.ack_o & if1.err_o) | (if2.ack_o & if2.err_o))) begin
      errors++;
      $display("FAIL ack_err_exclusive: got both high want at most one");
    end
  end

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_abort();
    test_out_of_range();
    test_reset_mid_wait();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
